// File: rtl/mdu_pkg.sv
// Shared constants and helpers for the RV32M multiply/divide unit.
// Op codes follow the RV32M funct3 encoding.
package mdu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MD_ITERS   = 32;
    localparam int CNT_W      = 6;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    function automatic logic [DATA_WIDTH-1:0] neg32(input logic [DATA_WIDTH-1:0] v);
        return ~v + 32'd1;
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Unsigned radix-2 iterative core: shift-add multiplier or restoring divider.
// Outputs present the post-iteration value, so they are final in the cycle done is high.
module mdu_iter
    import mdu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    is_div,
    input  logic [DATA_WIDTH-1:0]   mag_a,
    input  logic [DATA_WIDTH-1:0]   mag_b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic [DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]   remainder
);

    logic                    busy_q, busy_d;
    logic                    div_q, div_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     rem_sh;
    logic [DATA_WIDTH:0]     diff;
    logic [2*DATA_WIDTH-1:0] step;

    // Multiply keeps {hi, multiplier}; divide keeps {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        rem_sh  = {acc_q[63:32], acc_q[31]};
        diff    = rem_sh - {1'b0, opnd_q};
        if (div_q) begin
            if (diff[32]) begin
                step = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end else begin
                step = {diff[31:0], acc_q[30:0], 1'b1};
            end
        end else begin
            step = {mul_sum, acc_q[31:1]};
        end
        done      = busy_q && (cnt_q == CNT_W'(MD_ITERS - 1));
        product   = step;
        quotient  = step[31:0];
        remainder = step[63:32];
    end

    // Next-state for the iteration registers.
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (clear) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            div_d  = is_div;
            cnt_d  = '0;
            acc_d  = is_div ? {32'd0, mag_a} : {32'd0, mag_b};
            opnd_d = is_div ? mag_b : mag_a;
        end else if (busy_q) begin
            acc_d  = step;
            cnt_d  = cnt_q + 6'd1;
            busy_d = !done;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/mdu.sv
// RV32M multi-cycle multiply/divide unit: handshake, special-case detection
// and sign fix-up around the unsigned iterative core.
module mdu
    import mdu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  sign_q, sign_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic                    accept;
    logic                    div_zero;
    logic                    div_ovf;
    logic                    special;
    logic [DATA_WIDTH-1:0]   special_res;
    logic                    sign_in;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    iter_done;
    logic [2*DATA_WIDTH-1:0] iter_prod;
    logic [DATA_WIDTH-1:0]   iter_quot, iter_rem;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   calc_res;

    // Operand decode at accept: sign, magnitudes and the two cases that bypass the core.
    always_comb begin
        accept   = (state_q == S_IDLE) && in_valid && !flush;
        div_zero = op[2] && (b == 32'd0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                   (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = op[1] ? a : 32'hFFFF_FFFF;
        end else begin
            special_res = op[1] ? 32'd0 : 32'h8000_0000;
        end
        case (op)
            MD_MULH, MD_DIV:   sign_in = a[31] ^ b[31];
            MD_MULHSU, MD_REM: sign_in = a[31];
            default:           sign_in = 1'b0;
        endcase
        mag_a = (a_is_signed(op) && a[31]) ? neg32(a) : a;
        mag_b = (b_is_signed(op) && b[31]) ? neg32(b) : b;
    end

    mdu_iter u_iter (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .start     (accept && !special),
        .is_div    (op[2]),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .done      (iter_done),
        .product   (iter_prod),
        .quotient  (iter_quot),
        .remainder (iter_rem)
    );

    // Sign correction of the core result.
    always_comb begin
        prod_fix = sign_q ? (~iter_prod + 64'd1) : iter_prod;
        if (op_q[2]) begin
            if (op_q[1]) begin
                calc_res = sign_q ? neg32(iter_rem) : iter_rem;
            end else begin
                calc_res = sign_q ? neg32(iter_quot) : iter_quot;
            end
        end else begin
            calc_res = (op_q == MD_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
            S_CALC:  state_d = iter_done ? S_DONE : S_CALC;
            S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Registered outputs and per-operation context.
    always_comb begin
        op_d        = op_q;
        sign_d      = sign_q;
        result_d    = result_q;
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        if (accept) begin
            op_d     = op;
            sign_d   = sign_in;
            result_d = special ? special_res : result_q;
        end else if ((state_q == S_CALC) && iter_done && !flush) begin
            result_d = calc_res;
        end else begin
            result_d = result_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table with a result scoreboard,
// plus hand-written flush, reset and back-pressure sequences.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    mdu dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait for out_valid (bounded), hold off out_ready for 'hold' cycles.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat, input int hold);
        int n;
        logic [31:0] want;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        want = exp_q.pop_front();
        check("result", result, want);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", result, want);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33};
        vecs[6]  = '{3'd5, 32'd20,         32'd3,         32'd6,         33};
        vecs[7]  = '{3'd7, 32'd20,         32'd3,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};
        vecs[14] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[15] = '{3'd3, 32'h8000_0000,  32'd2,         32'd1,         33};
        vecs[16] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[17] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
        end

        // Back-pressure: result must hold while out_ready stays low.
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 10);

        // Flush in cycle 15 of CALC, then a back-to-back multiply.
        begin
            logic seen;
            @(negedge clk);
            op = 3'd5; a = 32'hFFFF_FFFF; b = 32'd1; in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (15) @(negedge clk);
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            check("flush_in_ready", {31'd0, in_ready}, 32'd1);
            check("flush_out_valid", {31'd0, out_valid}, 32'd0);
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            check("flush_no_valid", {31'd0, seen}, 32'd0);
        end
        do_op(3'd0, 32'd5, 32'd6, 32'd30, 33, 0);

        // Flush in the same cycle as an accept: nothing latched.
        begin
            logic seen;
            @(negedge clk);
            op = 3'd5; a = 32'd9; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0; flush = 1'b0;
            check("flush_acc_in_ready", {31'd0, in_ready}, 32'd1);
            seen = 1'b0;
            repeat (5) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            check("flush_acc_no_valid", {31'd0, seen}, 32'd0);
        end

        // Reset mid-CALC.
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        do_op(3'd7, 32'd50, 32'd8, 32'd2, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle RV32M multiply/divide unit, sitting in the execute stage beside the single-cycle ALU. It takes the M-extension ops the ALU cannot finish in one cycle. Operands are accepted with a valid/ready handshake. It runs a radix-2 iterative shift-add multiplier or restoring divider on operand magnitudes, applies the sign correction, and holds the result until the pipeline consumes it.

## Interface
- No parameters; width is `DATA_WIDTH` (32) from `defines.svh`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  pipeline kill; aborts any operation in progress.
- `in_valid`  in  1  operands and op present.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  3  RV32M funct3 encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `a`  in  `DATA_BUS`  rs1 value.
- `b`  in  `DATA_BUS`  rs2 value.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `result`  out  `DATA_BUS`  32-bit result.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - CALC: iterating.
  - DONE: `out_valid`=1.
- **Accept:** `in_valid && in_ready` in IDLE latches `op`, `a` and `b`.
  - Records the result sign.
    - MULH: `a[31]^b[31]`.
    - MULHSU: `a[31]`.
    - DIV: `a[31]^b[31]`.
    - REM: `a[31]`.
    - Unsigned ops: 0.
  - Loads magnitudes. The 32-bit two's-complement negation of 0x80000000 is 0x80000000, which is correct as an unsigned magnitude.
  - Clears the iteration counter (6 bits).
- **Multiply:** 64-bit product register, one multiplier bit per cycle, 32 iterations.
  - Final product is negated (64-bit) if the sign flag is set.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- **Divide:** restoring divider, 32 iterations, one quotient bit per cycle.
  - Quotient is negated if the sign flag is set (DIV).
  - Remainder is negated if the sign flag is set (REM).
- **Special cases:** detected at accept, skip CALC and go straight to DONE.
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **Result handling:**
  - Result is registered on entry to DONE.
  - `result` is stable while `out_valid && !out_ready`.
  - DONE to IDLE on `out_ready`.
- **Flush:** forces IDLE on the next edge from any state. Any pending result is discarded, and `out_valid` is low the following cycle.
- **Priority:** `rst` > `flush` > handshake. `in_valid` is ignored while `flush` is high.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, counter=0.
- **Normal latency:** accept at the edge ending cycle 0; CALC occupies cycles 1–32; `out_valid` first high in cycle 33.
- **Special-case latency:** `out_valid` high in cycle 1.
- **Throughput:** no overlap. The next accept is possible no earlier than the cycle after the result handshake, because `in_ready` is 0 throughout CALC and DONE.
- **No combinational paths:** `in_ready`, `out_valid` and `result` are purely registered. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Flush timing:**
  - Flush in the same cycle as the DONE handshake: the result counts as consumed and the state goes to IDLE.
  - Flush in the same cycle as an accept: nothing is latched.
- **Reset mid-operation:** identical to reset values on the next edge.

## Structure
- `defines.svh` gains:
  - `MD_MUL` … `MD_REMU` as 3-bit op constants.
  - `MD_ITERS` = 32.
- The state enum is local to `mdu`.
- One natural sub-module, `mdu_iter`, holds the unsigned iterative core:
  - Inputs: start, is_div, magnitudes.
  - Outputs: done pulse, 64-bit product or 32-bit quotient plus 32-bit remainder.
- The top level holds the handshake, the special-case detection and the sign fix-up.

## Test plan
- MUL `a`=7, `b`=-3 (0xFFFFFFFD) → `result`=0xFFFFFFEB, `out_valid` first high exactly 33 cycles after accept. MULH same operands → 0xFFFFFFFF.
- MULHU `a`=`b`=0xFFFFFFFF → 0xFFFFFFFE. MULHSU `a`=-1, `b`=0xFFFFFFFF → 0xFFFFFFFF.
- DIV `a`=-20, `b`=3 → 0xFFFFFFFA (−6); REM → 0xFFFFFFFE (−2); DIVU 20/3 → 6; REMU → 2.
- DIVU `b`=0, `a`=0x1234 → 0xFFFFFFFF; REMU → 0x1234; `out_valid` in cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; `out_valid` in cycle 1.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → `result` is constant and `in_ready`=0; release → next accept is legal in the following cycle.
- Assert `flush` in cycle 15 of CALC → IDLE next cycle, `out_valid` never rises. A back-to-back MUL 5×6 → 30 completes normally. `rst` mid-CALC → all outputs at reset values on the next edge.
